rr_mux_n_to_1: RTL and testbench

//   Parametrised W-bit, N-channel to 1 multiplexer with per-channel valid/ready handshake
//   and a registered output stage. Next generation of the combinational 1-bit N:1 mux.
//   Two source-selection modes:
//     - fixed: sel input picks the channel.
//     - round-robin: fair arbitration among channels presenting valid.

---
 rtl/rr_mux_n_to_1.sv | 87 ++++++++
 tb/tb_rr_mux_n_to_1.sv | 138 +++++++++++++
 2 files changed

// File: rtl/rr_mux_n_to_1.sv
// N-channel to 1 valid/ready mux with fixed-select or round-robin source choice.
// One-cycle latency through a single output register; stalls all inputs while it is full and blocked.
module rr_mux_n_to_1 #(
  parameter int N = 8,
  parameter int W = 8,
  localparam int M = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           mode,
  input  logic [M-1:0]   sel,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  output logic [W-1:0]   out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [M-1:0]   out_chan
);

  logic [W-1:0] r_out_data;
  logic         r_out_valid;
  logic [M-1:0] r_out_chan;
  logic [M-1:0] r_ptr;

  logic         w_can_accept;
  logic [M-1:0] w_gnt;
  logic         w_gnt_vld;
  logic [W-1:0] w_gnt_dat;
  logic         w_xfer;

  assign w_can_accept = !r_out_valid || out_ready;

  // Scan offsets from the top down so the smallest offset from ptr wins last.
  always_comb begin
    logic [M-1:0] idx;
    idx       = '0;
    w_gnt     = sel;
    w_gnt_vld = 1'b1;
    if (mode) begin
      w_gnt     = '0;
      w_gnt_vld = 1'b0;
      for (int k = N - 1; k >= 0; k--) begin
        idx = r_ptr + M'(k);
        if (in_valid[idx]) begin
          w_gnt     = idx;
          w_gnt_vld = 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_gnt_dat = '0;
    for (int i = 0; i < N; i++) begin
      if (w_gnt == M'(i)) w_gnt_dat = in_data[i*W +: W];
    end
  end

  always_comb begin
    in_ready = '0;
    if (rst_n && w_gnt_vld && w_can_accept) in_ready[w_gnt] = 1'b1;
  end

  assign w_xfer = w_gnt_vld && in_valid[w_gnt] && w_can_accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_chan  <= '0;
      r_ptr       <= '0;
    end else if (w_xfer) begin
      r_out_data  <= w_gnt_dat;
      r_out_chan  <= w_gnt;
      r_out_valid <= 1'b1;
      if (mode) r_ptr <= w_gnt + M'(1);
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_chan  = r_out_chan;

endmodule

// File: tb/tb_rr_mux_n_to_1.sv
// Bench for rr_mux_n_to_1: three configurations (N/W = 2/1, 8/8, 16/32), directed phases then random traffic.
module tb_rr_mux_n_to_1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [2:0] done = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  genvar gi;
  for (gi = 0; gi < 3; gi++) begin : g_cfg
    localparam int NN = (gi == 0) ? 2 : (gi == 1) ? 8 : 16;
    localparam int WW = (gi == 0) ? 1 : (gi == 1) ? 8 : 32;
    localparam int MM = $clog2(NN);
    localparam int TOTAL = 700;

    logic            rst_n;
    logic            mode;
    logic [MM-1:0]   sel;
    logic [NN*WW-1:0] in_data;
    logic [NN-1:0]   in_valid;
    logic [NN-1:0]   in_ready;
    logic [WW-1:0]   out_data;
    logic            out_valid;
    logic            out_ready;
    logic [MM-1:0]   out_chan;

    rr_mux_n_to_1 #(.N(NN), .W(WW)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .mode      (mode),
      .sel       (sel),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_chan  (out_chan)
    );

    initial begin
      // Reference state: the output register contents and the round-robin pointer.
      int exp_valid, exp_chan, ptr;
      logic [WW-1:0] exp_data;
      logic [NN-1:0] exp_rdy;
      int g, a, b;
      bit have_g, can;
      string pfx;

      pfx = $sformatf("N%0d", NN);
      a = NN / 4;
      b = (3 * NN) / 4;
      exp_valid = 0; exp_chan = 0; ptr = 0; exp_data = '0;
      rst_n = 1'b0; mode = 1'b0; sel = '0; in_valid = '0; out_ready = 1'b1; in_data = '0;

      for (int c = 0; c < TOTAL; c++) begin
        @(negedge clk);
        rst_n = 1'b1; mode = 1'b1; sel = '0; out_ready = 1'b1; in_valid = '1;
        for (int i = 0; i < NN; i++) in_data[i*WW +: WW] = WW'(32'h10 + i);
        if (c < 2) rst_n = 1'b0;
        else if (c < 10) begin mode = 1'b0; sel = MM'(3 % NN); end
        else if (c < 30) begin end
        else if (c < 40) in_valid = (NN'(1) << a) | (NN'(1) << b);
        else if (c < 44) in_valid = '0;
        else if (c < 50) out_ready = !(c >= 45 && c < 48);
        else if (c < 58) begin end
        else if (c < 62) out_ready = 1'b0;
        else if (c < 63) begin rst_n = 1'b0; out_ready = 1'b0; end
        else if (c < 70) begin end
        else begin
          rst_n = ($urandom_range(0, 63) != 0);
          mode = ($urandom_range(0, 3) != 0);
          sel = MM'($urandom);
          in_valid = NN'({$urandom, $urandom});
          if ($urandom_range(0, 4) == 0) in_valid = '0;
          out_ready = ($urandom_range(0, 3) != 0);
          for (int i = 0; i < NN; i++) in_data[i*WW +: WW] = WW'($urandom);
        end
        #1;
        if (!rst_n) begin
          exp_valid = 0; exp_chan = 0; ptr = 0; exp_data = '0;
        end

        can = (exp_valid == 0) || out_ready;
        have_g = 1'b0;
        g = 0;
        if (!mode) begin
          have_g = 1'b1;
          g = int'(sel);
        end else begin
          for (int k = 0; k < NN; k++) begin
            if (!have_g && in_valid[(ptr + k) % NN]) begin
              have_g = 1'b1;
              g = (ptr + k) % NN;
            end
          end
        end
        exp_rdy = '0;
        if (rst_n && have_g && can) exp_rdy[g] = 1'b1;

        chk({pfx, " in_ready"}, 64'(in_ready), 64'(exp_rdy));
        chk({pfx, " out_valid"}, 64'(out_valid), 64'(exp_valid));
        chk({pfx, " out_data"}, 64'(out_data), 64'(exp_data));
        chk({pfx, " out_chan"}, 64'(out_chan), 64'(exp_chan));

        if (rst_n) begin
          if (have_g && in_valid[g] && can) begin
            exp_data = in_data[g*WW +: WW];
            exp_chan = g;
            exp_valid = 1;
            if (mode) ptr = (g + 1) % NN;
          end else if (exp_valid != 0 && out_ready) begin
            exp_valid = 0;
          end
        end
      end
      done[gi] = 1'b1;
    end
  end

  initial begin
    for (int t = 0; t < 20000 && !(&done); t++) @(posedge clk);
    chk("all_done", 64'(&done), 64'd1);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
